// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: pops endpoints from a line queue and
// streams clipped pixels to a frame-buffer writer over valid/ready.
module line_rasterizer #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [10:0] QStartX,
  input  logic [10:0] QStartY,
  input  logic [10:0] QEndX,
  input  logic [10:0] QEndY,
  input  logic [2:0]  QColor,
  input  logic        empty,
  output logic        read,
  output logic [10:0] pixX,
  output logic [10:0] pixY,
  output logic [2:0]  pixColor,
  output logic        pixValid,
  input  logic        pixReady,
  output logic        busy,
  output logic [15:0] linesDrawn
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  state_t             state_q, state_d;
  logic        [10:0] cur_x_q, cur_x_d;
  logic        [10:0] cur_y_q, cur_y_d;
  logic        [10:0] end_x_q, end_x_d;
  logic        [10:0] end_y_q, end_y_d;
  logic        [2:0]  col_q, col_d;
  logic signed [13:0] dx_q, dx_d;
  logic signed [13:0] dy_q, dy_d;
  logic signed [13:0] err_q, err_d;
  logic               sxn_q, sxn_d;
  logic               syn_q, syn_d;
  logic        [15:0] lines_q, lines_d;

  logic signed [13:0] ddx, ddy, adx, ady;
  logic signed [14:0] e2, dx15, dy15;
  logic signed [13:0] err_n;
  logic               x_ok, y_ok, in_rng;
  logic               drawing, step, at_end;

  // Deltas between the latched start (held in cur) and end point
  always_comb begin
    ddx  = {{3{end_x_q[10]}}, end_x_q} - {{3{cur_x_q[10]}}, cur_x_q};
    ddy  = {{3{end_y_q[10]}}, end_y_q} - {{3{cur_y_q[10]}}, cur_y_q};
    adx  = ddx[13] ? -ddx : ddx;
    ady  = ddy[13] ? -ddy : ddy;
    e2   = {err_q, 1'b0};
    dx15 = {dx_q[13], dx_q};
    dy15 = {dy_q[13], dy_q};
  end

  // Visibility of the current point and handshake-driven step
  always_comb begin
    x_ok    = !cur_x_q[10] && ({21'd0, cur_x_q} < 32'(SCREEN_W));
    y_ok    = !cur_y_q[10] && ({21'd0, cur_y_q} < 32'(SCREEN_H));
    in_rng  = x_ok && y_ok;
    drawing = (state_q == DRAW);
    step    = drawing && (!in_rng || pixReady);
    at_end  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  end

  // Next-state and pop strobe
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    end_x_d = end_x_q;
    end_y_d = end_y_q;
    col_d   = col_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    lines_d = lines_q;
    err_n   = err_q;
    read    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          read    = 1'b1;
          cur_x_d = QStartX;
          cur_y_d = QStartY;
          end_x_d = QEndX;
          end_y_d = QEndY;
          col_d   = QColor;
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d    = adx;
        dy_d    = -ady;
        sxn_d   = ddx[13];
        syn_d   = ddy[13];
        err_d   = adx - ady;
        state_d = (col_q == 3'd0) ? IDLE : DRAW;
      end
      DRAW: begin
        if (step) begin
          if (at_end) begin
            state_d = IDLE;
            lines_d = lines_q + 16'd1;
          end else begin
            if (e2 >= dy15) begin
              err_n   = err_n + dy_q;
              cur_x_d = cur_x_q + (sxn_q ? 11'h7FF : 11'h001);
            end
            if (e2 <= dx15) begin
              err_n   = err_n + dx_q;
              cur_y_d = cur_y_q + (syn_q ? 11'h7FF : 11'h001);
            end
            err_d = err_n;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      col_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      end_x_q <= end_x_d;
      end_y_q <= end_y_d;
      col_q   <= col_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      lines_q <= lines_d;
    end
  end

  // Pixel outputs are zero outside DRAW so reset clears them
  always_comb begin
    pixValid   = drawing && in_rng;
    pixX       = drawing ? cur_x_q : 11'd0;
    pixY       = drawing ? cur_y_q : 11'd0;
    pixColor   = drawing ? col_q : 3'd0;
    busy       = (state_q != IDLE);
    linesDrawn = lines_q;
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: line-queue model feeds the DUT,
// expected pixels go to a scoreboard checked on each accept.
module tb_line_rasterizer;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  c;
  } pix_t;

  typedef struct packed {
    logic [10:0] sx;
    logic [10:0] sy;
    logic [10:0] ex;
    logic [10:0] ey;
    logic [2:0]  c;
  } line_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [10:0] QStartX, QStartY, QEndX, QEndY;
  logic [2:0]  QColor;
  logic        empty;
  logic        read;
  logic [10:0] pixX, pixY;
  logic [2:0]  pixColor;
  logic        pixValid;
  logic        pixReady;
  logic        busy;
  logic [15:0] linesDrawn;

  line_rasterizer dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .QStartX    (QStartX),
    .QStartY    (QStartY),
    .QEndX      (QEndX),
    .QEndY      (QEndY),
    .QColor     (QColor),
    .empty      (empty),
    .read       (read),
    .pixX       (pixX),
    .pixY       (pixY),
    .pixColor   (pixColor),
    .pixValid   (pixValid),
    .pixReady   (pixReady),
    .busy       (busy),
    .linesDrawn (linesDrawn)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    vcnt = 0;
  int    bcnt = 0;
  int    hold_cnt = 0;
  logic  pop_next = 1'b0;
  line_t lq[$];
  pix_t  sb[$];
  int    rd_log[$];
  int    acc_log[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    if (lq.size() == 0) begin
      empty = 1'b1;
      QStartX = '0; QStartY = '0; QEndX = '0; QEndY = '0; QColor = '0;
    end else begin
      empty   = 1'b0;
      QStartX = lq[0].sx;
      QStartY = lq[0].sy;
      QEndX   = lq[0].ex;
      QEndY   = lq[0].ey;
      QColor  = lq[0].c;
    end
  endtask

  task automatic push_line(input int sx, input int sy, input int ex,
                           input int ey, input int c);
    line_t l;
    l.sx = 11'(sx); l.sy = 11'(sy);
    l.ex = 11'(ex); l.ey = 11'(ey);
    l.c  = 3'(c);
    lq.push_back(l);
    refresh();
  endtask

  task automatic exp_pix(input int x, input int y, input int c);
    pix_t p;
    p.x = 11'(x); p.y = 11'(y); p.c = 3'(c);
    sb.push_back(p);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    acc_log.delete();
    vcnt = 0;
    bcnt = 0;
  endtask

  task automatic wait_idle(input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk); #1;
      if (lq.size() == 0 && !busy && !pop_next && !read) done = 1'b1;
    end
    chk("wait_idle", {31'd0, done}, 32'd1);
  endtask

  always @(posedge clk) cyc++;

  // Queue pop lands just after the edge on which the DUT latched the head
  always @(posedge clk) begin
    if (pop_next) begin
      #1;
      void'(lq.pop_front());
      pop_next = 1'b0;
      refresh();
    end
  end

  // Monitor: handshake log, scoreboard compare, protocol checks
  always @(negedge clk) begin
    pix_t e;
    pix_t o;
    if (pixValid) vcnt++;
    if (busy) bcnt++;
    if (pixValid && pixX == 11'd1 && pixY == 11'd0) hold_cnt++;
    chk("read_when_empty", {31'd0, read && empty}, 32'd0);
    if (read && rst_b) begin
      rd_log.push_back(cyc);
      pop_next = 1'b1;
    end
    if (pixValid && pixReady && rst_b) begin
      acc_log.push_back(cyc);
      chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        o.x = pixX; o.y = pixY; o.c = pixColor;
        chk("pixel", {7'd0, o}, {7'd0, e});
      end
    end
  end

  initial begin
    int n_rd;
    logic got;
    pixReady = 1'b1;
    rst_b = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixValid", {31'd0, pixValid}, 32'd0);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_lines", {16'd0, linesDrawn}, 32'd0);
    chk("rst_pixX", {21'd0, pixX}, 32'd0);
    chk("rst_pixY", {21'd0, pixY}, 32'd0);
    chk("rst_color", {29'd0, pixColor}, 32'd0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Horizontal line, full-rate accept
    clear_logs();
    exp_pix(0, 0, 5); exp_pix(1, 0, 5); exp_pix(2, 0, 5); exp_pix(3, 0, 5);
    push_line(0, 0, 3, 0, 5);
    wait_idle(50);
    chk("h_reads", rd_log.size(), 1);
    chk("h_accepts", acc_log.size(), 4);
    chk("h_first_lat", acc_log[0] - rd_log[0], 2);
    chk("h_consec", acc_log[3] - acc_log[0], 3);
    chk("h_busy_cyc", bcnt, 5);
    chk("h_lines", {16'd0, linesDrawn}, 32'd1);
    chk("h_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // Shallow diagonal
    clear_logs();
    exp_pix(0, 0, 2); exp_pix(1, 1, 2); exp_pix(2, 1, 2);
    exp_pix(3, 2, 2); exp_pix(4, 2, 2);
    push_line(0, 0, 4, 2, 2);
    wait_idle(50);
    chk("d_accepts", acc_log.size(), 5);
    chk("d_lines", {16'd0, linesDrawn}, 32'd2);
    chk("d_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // Zero-length then reverse diagonal, back to back
    clear_logs();
    exp_pix(7, 9, 1);
    exp_pix(2, 2, 4); exp_pix(1, 1, 4); exp_pix(0, 0, 4);
    push_line(7, 9, 7, 9, 1);
    push_line(2, 2, 0, 0, 4);
    wait_idle(80);
    chk("b_reads", rd_log.size(), 2);
    chk("b_accepts", acc_log.size(), 4);
    chk("b_next_pop", rd_log[1] - acc_log[0], 1);
    chk("b_second_lat", acc_log[1] - rd_log[1], 2);
    chk("b_lines", {16'd0, linesDrawn}, 32'd4);
    chk("b_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // Back-pressure on the second pixel
    clear_logs();
    exp_pix(0, 0, 3); exp_pix(1, 0, 3); exp_pix(2, 0, 3); exp_pix(3, 0, 3);
    push_line(0, 0, 3, 0, 3);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (rd_log.size() != 0) got = 1'b1;
    end
    chk("s_read_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold_cnt = 0;
    @(posedge clk); #1;
    pixReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pixReady = 1'b1;
    wait_idle(50);
    chk("s_hold_cycles", hold_cnt, 4);
    chk("s_accepts", acc_log.size(), 4);
    chk("s_lines", {16'd0, linesDrawn}, 32'd5);
    chk("s_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // Line starting off-screen to the left
    clear_logs();
    exp_pix(0, 0, 6); exp_pix(1, 0, 6);
    push_line(-2, 0, 1, 0, 6);
    wait_idle(50);
    chk("c_busy_cyc", bcnt, 5);
    chk("c_valid_cyc", vcnt, 2);
    chk("c_lines", {16'd0, linesDrawn}, 32'd6);
    chk("c_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // Blanked line
    clear_logs();
    push_line(0, 0, 5, 5, 0);
    wait_idle(50);
    chk("z_reads", rd_log.size(), 1);
    chk("z_valid_cyc", vcnt, 0);
    chk("z_busy_cyc", bcnt, 1);
    chk("z_lines", {16'd0, linesDrawn}, 32'd6);
    @(posedge clk); #1;

    // Reset in the middle of a long line
    clear_logs();
    for (int i = 0; i <= 10; i++) exp_pix(i, 0, 7);
    push_line(0, 0, 10, 0, 7);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); #1;
      if (acc_log.size() >= 4) got = 1'b1;
    end
    chk("r_progress", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("r_pixValid", {31'd0, pixValid}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_lines", {16'd0, linesDrawn}, 32'd0);
    chk("r_pixX", {21'd0, pixX}, 32'd0);
    chk("r_color", {29'd0, pixColor}, 32'd0);
    sb.delete();
    rst_b = 1'b1;
    n_rd = rd_log.size();
    vcnt = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("r_no_reread", rd_log.size(), n_rd);
    chk("r_no_pixels", vcnt, 0);
    chk("r_read_low", {31'd0, read}, 32'd0);
    chk("r_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
